// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - memory-side responder: word/sub-word loads and stores against a word-wide sync RAM
module mem_port_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ready,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_WR, S_RD_WAIT, S_MERGE, S_DONE} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                misalign_q, misalign_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_q, mem_wr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic                mis;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_val;
  logic [31:0]         merged;

  // Lane extraction and merge operate directly on the RAM word as it is captured.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    if (size_q == 2'b01) begin
      load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
    end else if (size_q == 2'b10) begin
      load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
    end
    merged = mem_rdata;
    if (size_q == 2'b01) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = 1'b0;
    misalign_d  = 1'b0;
    mem_wr_d    = 1'b0;
    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b00 && addr[1:0] != 2'b00);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lane_d     = addr[1:0];
          size_d     = size;
          we_d       = we;
          uns_d      = ld_unsigned;
          wdata_d    = wdata[15:0];
          cnt_d      = 2'd0;
          mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
          if (mis) begin
            state_d    = S_ERR;
            ready_d    = 1'b1;
            misalign_d = 1'b1;
          end else if (we && size == 2'b00) begin
            state_d     = S_WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = wdata;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_ERR: state_d = S_IDLE;
      S_WR: begin
        state_d = S_DONE;
        ready_d = 1'b1;
      end
      S_RD_WAIT: begin
        if (cnt_q == LAT) begin
          if (we_q) begin
            state_d     = S_MERGE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d = S_DONE;
            ready_d = 1'b1;
            rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_MERGE: begin
        state_d = S_DONE;
        ready_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Asynchronous clear drops mem_wr mid-access so no partial write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed and random checks of mem_port_ctrl against a behavioural RAM model
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req3, we, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, ready, misalign, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy3, ready3, misalign3, mem_wr3;
  logic [31:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] ram [64];
  logic [31:0] shadow [64];
  logic [31:0] p1, p3a, p3b, p3c;
  int          wr_count = 0;
  logic [31:0] last_wa, last_wd;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_port_ctrl #(.ADDR_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .size(size), .ld_unsigned(ld_unsigned),
    .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .misalign(misalign), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_ctrl #(.ADDR_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .req(req3), .we(we), .size(size), .ld_unsigned(ld_unsigned),
    .addr(addr), .wdata(wdata), .busy(busy3), .ready(ready3), .misalign(misalign3), .rdata(rdata3),
    .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Synchronous RAM: read pipeline depth 1 for u_dut, 3 for u_dut3 (read-only port).
  always @(posedge clk) begin
    p1  <= ram[mem_addr[7:2]];
    p3a <= ram[mem_addr3[7:2]];
    p3b <= p3a;
    p3c <= p3b;
    if (mem_wr) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wdata;
    end
  end
  assign mem_rdata  = p1;
  assign mem_rdata3 = p3c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [7:0] a,
                                           input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    if (sz == 2'd0) return word;
    if (sz == 2'd1) begin
      v = (word >> (16 * int'(a[1]))) & 32'h0000FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = (word >> (8 * int'(a[1:0]))) & 32'h000000FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] word, input logic [7:0] a,
                                           input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) return d;
    mask = (sz == 2'd1) ? 32'h0000FFFF : 32'h000000FF;
    sh   = 8 * int'(a[1:0]);
    return (word & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  function automatic bit is_mis(input logic [7:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd0 && a % 4 != 0);
  endfunction

  task automatic do_access(input bit w, input logic [1:0] sz, input bit uns,
                           input logic [7:0] a, input logic [31:0] wd, input bit noise);
    int          cyc, w0, lat, nwr;
    bit          mis;
    logic [31:0] nw;
    mis = is_mis(a, sz);
    nw  = st_model(shadow[a[7:2]], a, sz, wd);
    lat = mis ? 1 : (w && sz == 2'd0) ? 2 : !w ? 3 : 4;
    nwr = (w && !mis) ? 1 : 0;
    if (!w && !mis) exp_rdata = ld_model(shadow[a[7:2]], a, sz, uns);
    w0 = wr_count;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; ld_unsigned = uns; addr = {24'd0, a}; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    while (!ready && cyc < 12) begin
      if (noise) req = 1'($urandom % 2);
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    check("latency", cyc, lat);
    check("ready", 32'(ready), 32'd1);
    check("misalign", 32'(misalign), 32'(mis));
    check("rdata", rdata, exp_rdata);
    check("mem_addr", mem_addr, {24'd0, a[7:2], 2'b00});
    @(negedge clk);
    check("ready_pulse", 32'(ready), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("write_count", 32'(wr_count - w0), 32'(nwr));
    if (nwr == 1) begin
      check("write_addr", last_wa, {24'd0, a[7:2], 2'b00});
      check("write_data", last_wd, nw);
      shadow[a[7:2]] = nw;
    end
  endtask

  task automatic do_lat3(input logic [1:0] sz, input bit uns, input logic [7:0] a);
    int cyc;
    @(negedge clk);
    req3 = 1'b1; we = 1'b0; size = sz; ld_unsigned = uns; addr = {24'd0, a};
    @(negedge clk);
    req3 = 1'b0;
    cyc = 1;
    while (!ready3 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("lat3_latency", cyc, 5);
    check("lat3_rdata", rdata3, ld_model(shadow[a[7:2]], a, sz, uns));
    check("lat3_no_write", 32'(mem_wr3), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int          cyc, bad;
    logic [7:0]  ra;
    for (int i = 0; i < 64; i++) begin
      ram[i]    = 32'd0;
      shadow[i] = 32'd0;
    end
    rst_n = 1'b0; req = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'd0;
    ld_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_access(1'b1, 2'd0, 1'b0, 8'h40, 32'hDEADBEEF, 1'b0);
    do_access(1'b0, 2'd0, 1'b0, 8'h40, 32'h0, 1'b0);
    check("word_roundtrip", rdata, 32'hDEADBEEF);

    do_access(1'b1, 2'd0, 1'b0, 8'h40, 32'h80F17F02, 1'b0);
    do_access(1'b0, 2'd2, 1'b0, 8'h43, 32'h0, 1'b0);
    check("byte_signed", rdata, 32'hFFFFFF80);
    do_access(1'b0, 2'd2, 1'b1, 8'h43, 32'h0, 1'b0);
    check("byte_unsigned", rdata, 32'h00000080);
    do_access(1'b0, 2'd1, 1'b0, 8'h42, 32'h0, 1'b0);
    check("half_hi_signed", rdata, 32'hFFFF80F1);
    do_access(1'b0, 2'd1, 1'b0, 8'h40, 32'h0, 1'b0);
    check("half_lo_signed", rdata, 32'h00007F02);

    do_access(1'b1, 2'd0, 1'b0, 8'h40, 32'h11223344, 1'b0);
    do_access(1'b1, 2'd2, 1'b0, 8'h41, 32'h000000AB, 1'b0);
    check("rmw_ram", ram[16], 32'h1122AB44);

    do_access(1'b0, 2'd0, 1'b0, 8'h42, 32'h0, 1'b0);
    do_access(1'b1, 2'd1, 1'b0, 8'h41, 32'h5555, 1'b0);
    do_access(1'b0, 2'd3, 1'b0, 8'h40, 32'h0, 1'b0);
    check("mis_rdata_kept", rdata, 32'h00007F02);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      do_access(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), ra, $urandom, 1'b1);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== shadow[i]) bad++;
    check("ram_vs_model", 32'(bad), 32'd0);

    do_lat3(2'd0, 1'b0, 8'h40);
    do_lat3(2'd2, 1'b0, 8'h41);

    do_access(1'b1, 2'd0, 1'b0, 8'h80, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; ld_unsigned = 1'b0; addr = 32'h81; wdata = 32'h77;
    @(negedge clk);
    req = 1'b0;
    cyc = 0;
    while (!mem_wr && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("merge_reached", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_wr", 32'(mem_wr), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    check("abort_ram_kept", ram[32], 32'hCAFEF00D);
    check("abort_rdata_clr", rdata, 32'd0);
    do_access(1'b0, 2'd0, 1'b0, 8'h80, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
